// File: rtl/decoder24_arbiter.sv
// decoder24_arbiter: round-robin owner of a shared 2-to-4 decoder, break-before-make with bounded hold
module decoder24_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       sel_a,
   output logic       sel_b,
   output logic       en_n,
   output logic       busy
);
   localparam int CW = $clog2(HOLD_MAX + 1);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t state, state_nx;
   logic [1:0] cur, cur_nx, last, last_nx, win;
   logic [CW-1:0] cnt, cnt_nx;
   // descending scan so the nearest requester after last overrides farther ones
   always_comb begin
      win = last;
      for (int k = 4; k >= 1; k--) if (req[last + 2'(k)]) win = last + 2'(k);
   end
   always_comb begin
      state_nx = state;
      cur_nx = cur;
      last_nx = last;
      cnt_nx = cnt;
      if (state == GRANT) begin
         if (!req[cur] || cnt == CW'(HOLD_MAX)) begin
            state_nx = RELEASE;
            last_nx = cur;
         end else cnt_nx = cnt + CW'(1);
      end else if (|req) begin
         state_nx = GRANT;
         cur_nx = win;
         cnt_nx = CW'(1);
      end else state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cur <= 2'd0;
         last <= 2'd3;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cur <= cur_nx;
         last <= last_nx;
         cnt <= cnt_nx;
      end
   end
   assign busy = state == GRANT;
   assign gnt = busy ? 4'b0001 << cur : 4'b0000;
   assign {sel_a, sel_b} = cur;
   assign en_n = !busy;
endmodule
